// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the two imem requesters, the arbiter and the
// single-port instruction memory.
// The slave modport is the arbiter's view. The master modport is the view of
// the environment that drives requests and models the memory.
interface imem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    // fetch requester (read-only)
    logic                  fetch_req_valid_i;
    logic                  fetch_req_ready_o;
    logic [ADDR_WIDTH-1:0] fetch_addr_i;
    logic                  fetch_flush_i;
    logic                  fetch_rsp_valid_o;
    logic [DATA_WIDTH-1:0] fetch_rsp_instr_o;
    logic                  fetch_rsp_err_o;

    // loader / debug requester (read/write)
    logic                  ld_req_valid_i;
    logic                  ld_req_ready_o;
    logic                  ld_we_i;
    logic [ADDR_WIDTH-1:0] ld_addr_i;
    logic [DATA_WIDTH-1:0] ld_wdata_i;
    logic                  ld_lock_i;
    logic                  ld_rsp_valid_o;
    logic [DATA_WIDTH-1:0] ld_rsp_rdata_o;
    logic                  ld_rsp_err_o;

    // single-port synchronous memory
    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [IDX_W-1:0]      mem_widx_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  fetch_req_valid_i, fetch_addr_i, fetch_flush_i,
        output fetch_req_ready_o, fetch_rsp_valid_o, fetch_rsp_instr_o, fetch_rsp_err_o,
        input  ld_req_valid_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_lock_i,
        output ld_req_ready_o, ld_rsp_valid_o, ld_rsp_rdata_o, ld_rsp_err_o,
        output mem_en_o, mem_we_o, mem_widx_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output fetch_req_valid_i, fetch_addr_i, fetch_flush_i,
        input  fetch_req_ready_o, fetch_rsp_valid_o, fetch_rsp_instr_o, fetch_rsp_err_o,
        output ld_req_valid_i, ld_we_i, ld_addr_i, ld_wdata_i, ld_lock_i,
        input  ld_req_ready_o, ld_rsp_valid_o, ld_rsp_rdata_o, ld_rsp_err_o,
        input  mem_en_o, mem_we_o, mem_widx_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port synchronous instruction memory
// between the core fetch unit (read-only) and a loader/debug port (read/write).
//  - Fetch has fixed priority. A loader that is denied STARVE_LIMIT cycles in a
//    row is forced through on the next cycle.
//  - ld_lock_i (program-load mode) shuts fetch out completely.
//  - The response is produced one cycle after the grant. The owner and fault
//    status are registered at the grant. The data comes from the memory read
//    port in the response cycle.
//  - A misaligned or out-of-range access is accepted but never reaches the
//    memory. A faulting fetch returns NOP_INSTR.
// Optional build macro: IMEM_ARB_PERF_EN adds fetch grant, loader grant and
// fetch stall event counters. Without it the perf ports are tied to zero.
module imem_port_arbiter #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MEM_WORDS    = 1024,
    parameter int unsigned           STARVE_LIMIT = 8,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_port_arbiter_if.slave  bus,
    output logic [31:0]         perf_fetch_grants_o,
    output logic [31:0]         perf_ld_grants_o,
    output logic [31:0]         perf_fetch_stall_o
);

    localparam int unsigned           IDX_W       = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_A = ADDR_WIDTH'(MEM_WORDS);
    localparam logic [7:0]            STARVE_MAX  = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LD    = 2'd2
    } owner_e;

    // True when a byte address is word aligned and maps inside the memory.
    // The range test runs on the whole shifted address, so high bits never
    // alias back onto a valid word.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
        logic aligned;
        logic in_range;
        aligned  = (addr[1:0] == 2'b00);
        in_range = ((addr >> 2) < MEM_WORDS_A);
        return aligned && in_range;
    endfunction

    // arbitration
    logic                  fetch_elig_s;
    logic                  starve_full_s;
    logic                  grant_fetch_s;
    logic                  grant_ld_s;
    logic                  grant_any_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic                  sel_ok_s;

    // state
    logic [7:0]            starve_d, starve_q;
    owner_e                owner_d, owner_q;
    logic                  fault_d, fault_q;
    logic                  wr_d, wr_q;

    // Grant selection. There is at most one winner per cycle, and no grant while in reset.
    always_comb begin
        fetch_elig_s  = bus.fetch_req_valid_i && !bus.fetch_flush_i && !bus.ld_lock_i;
        starve_full_s = (starve_q == STARVE_MAX);
        grant_fetch_s = 1'b0;
        grant_ld_s    = 1'b0;
        if (!rst_n) begin
            grant_fetch_s = 1'b0;
            grant_ld_s    = 1'b0;
        end else if (bus.ld_lock_i) begin
            grant_ld_s    = bus.ld_req_valid_i;
        end else if (starve_full_s && bus.ld_req_valid_i) begin
            grant_ld_s    = 1'b1;
        end else if (fetch_elig_s) begin
            grant_fetch_s = 1'b1;
        end else begin
            grant_ld_s    = bus.ld_req_valid_i;
        end
        grant_any_s = grant_fetch_s || grant_ld_s;
    end

    // Address check on the winning request and memory port drive.
    // A faulting access is accepted but never enables the memory.
    always_comb begin
        if (grant_ld_s) begin
            sel_addr_s = bus.ld_addr_i;
        end else begin
            sel_addr_s = bus.fetch_addr_i;
        end
        sel_ok_s = addr_ok(sel_addr_s);

        bus.fetch_req_ready_o = grant_fetch_s;
        bus.ld_req_ready_o    = grant_ld_s;
        bus.mem_en_o          = grant_any_s && sel_ok_s;
        bus.mem_we_o          = grant_ld_s && sel_ok_s && bus.ld_we_i;
        if (bus.mem_en_o) begin
            bus.mem_widx_o = sel_addr_s[IDX_W+1:2];
        end else begin
            bus.mem_widx_o = {IDX_W{1'b0}};
        end
        if (bus.mem_we_o) begin
            bus.mem_wdata_o = bus.ld_wdata_i;
        end else begin
            bus.mem_wdata_o = {DATA_WIDTH{1'b0}};
        end
    end

    // Next state for the starvation counter and the response stage.
    // The counter runs while the loader waits. It saturates at the limit and
    // restarts as soon as the loader is served or withdraws its request.
    always_comb begin
        if (!bus.ld_req_valid_i || grant_ld_s) begin
            starve_d = 8'd0;
        end else if (starve_full_s) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + 8'd1;
        end

        if (grant_fetch_s) begin
            owner_d = OWN_FETCH;
        end else if (grant_ld_s) begin
            owner_d = OWN_LD;
        end else begin
            owner_d = OWN_NONE;
        end
        fault_d = grant_any_s && !sel_ok_s;
        wr_d    = grant_ld_s && bus.ld_we_i;
    end

    // Registered starvation counter and response-stage owner/status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= 8'd0;
            owner_q  <= OWN_NONE;
            fault_q  <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
            fault_q  <= fault_d;
            wr_q     <= wr_d;
        end
    end

    // Response outputs, built from the registered stage and the memory read data.
    // A flush in the response cycle kills only a fetch response.
    always_comb begin
        bus.fetch_rsp_valid_o = rst_n && (owner_q == OWN_FETCH) && !bus.fetch_flush_i;
        bus.fetch_rsp_err_o   = bus.fetch_rsp_valid_o && fault_q;
        if (rst_n && (owner_q == OWN_FETCH)) begin
            if (fault_q) begin
                bus.fetch_rsp_instr_o = NOP_INSTR;
            end else begin
                bus.fetch_rsp_instr_o = bus.mem_rdata_i;
            end
        end else begin
            bus.fetch_rsp_instr_o = {DATA_WIDTH{1'b0}};
        end

        bus.ld_rsp_valid_o = rst_n && (owner_q == OWN_LD);
        bus.ld_rsp_err_o   = bus.ld_rsp_valid_o && fault_q;
        if (bus.ld_rsp_valid_o && !fault_q && !wr_q) begin
            bus.ld_rsp_rdata_o = bus.mem_rdata_i;
        end else begin
            bus.ld_rsp_rdata_o = {DATA_WIDTH{1'b0}};
        end
    end

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_fg_d, perf_fg_q;
    logic [31:0] perf_lg_d, perf_lg_q;
    logic [31:0] perf_st_d, perf_st_q;

    // Event counter increments. All three wrap naturally on overflow.
    always_comb begin
        perf_fg_d = perf_fg_q + {31'd0, grant_fetch_s};
        perf_lg_d = perf_lg_q + {31'd0, grant_ld_s};
        perf_st_d = perf_st_q + {31'd0, (bus.fetch_req_valid_i && !grant_fetch_s)};
    end

    // Event counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fg_q <= 32'd0;
            perf_lg_q <= 32'd0;
            perf_st_q <= 32'd0;
        end else begin
            perf_fg_q <= perf_fg_d;
            perf_lg_q <= perf_lg_d;
            perf_st_q <= perf_st_d;
        end
    end

    // Counter outputs.
    always_comb begin
        perf_fetch_grants_o = perf_fg_q;
        perf_ld_grants_o    = perf_lg_q;
        perf_fetch_stall_o  = perf_st_q;
    end
`else
    // Perf ports are present but constant when counters are not built.
    always_comb begin
        perf_fetch_grants_o = 32'd0;
        perf_ld_grants_o    = 32'd0;
        perf_fetch_stall_o  = 32'd0;
    end
`endif

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port synchronous instruction memory between two requesters:
  - the core fetch unit (read-only);
  - a loader/debug port (read/write), used to program or inspect imem.
- Fixed priority to fetch, with a starvation override for the loader.
- 1-cycle registered response.
- Bounds/alignment checking; faulting fetches return NOP.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both requester ports.
- DATA_WIDTH, 32, word width.
- MEM_WORDS, 1024, memory depth in words (power of two).
- STARVE_LIMIT, 8, consecutive denied loader cycles before forced loader grant (1..255).
- NOP_INSTR, 32'h00000013, word returned on a faulting fetch.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- fetch_req_valid_i  in  1  fetch read request.
- fetch_req_ready_o  out  1  fetch request accepted this cycle.
- fetch_addr_i  in  ADDR_WIDTH  fetch byte address.
- fetch_flush_i  in  1  kill in-flight fetch response (redirect).
- fetch_rsp_valid_o  out  1  fetch response valid.
- fetch_rsp_instr_o  out  DATA_WIDTH  fetched instruction.
- fetch_rsp_err_o  out  1  misaligned or out-of-range fetch.
- ld_req_valid_i  in  1  loader request.
- ld_req_ready_o  out  1  loader request accepted.
- ld_we_i  in  1  1=write, 0=read.
- ld_addr_i  in  ADDR_WIDTH  loader byte address.
- ld_wdata_i  in  DATA_WIDTH  write data.
- ld_lock_i  in  1  program-load mode; blocks all fetch grants.
- ld_rsp_valid_o  out  1  loader response (read data or write ack).
- ld_rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes/errors.
- ld_rsp_err_o  out  1  misaligned or out-of-range loader access.
- mem_en_o  out  1  memory access enable.
- mem_we_o  out  1  memory write enable.
- mem_widx_o  out  $clog2(MEM_WORDS)  word index.
- mem_wdata_o  out  DATA_WIDTH  write data.
- mem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after mem_en_o.

Behaviour:
- Reset (rst_n=0 at posedge):
  - all rsp_valid/err outputs = 0; rsp data = 0;
  - starve counter = 0; response-owner register = NONE.
  - Ready outputs and mem_* are combinational. While rst_n=0 they are forced to 0.
- Arbitration is evaluated each cycle, with at most one grant per cycle:
  1. ld_lock_i=1: only the loader is eligible.
  2. Else if starve_cnt == STARVE_LIMIT and ld_req_valid_i: loader is granted.
  3. Else fetch wins if fetch_req_valid_i and fetch_flush_i=0. Otherwise the loader wins if valid.
- Readiness:
  - fetch_req_ready_o = grant to fetch.
  - ld_req_ready_o = grant to loader.
  - fetch_req_ready_o is 0 whenever fetch_flush_i=1.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle ld_req_valid_i=1 without a loader grant.
  - Clears on a loader grant or when ld_req_valid_i=0.
- Address check on the granted request:
  - aligned = addr[1:0]==0;
  - in range = (addr>>2) < MEM_WORDS, compared at full ADDR_WIDTH, with no masking or wrap.
  - Valid access: mem_en_o=1, mem_widx_o=addr>>2, mem_we_o=ld_we_i (loader only, never for fetch).
  - Faulting access: mem_en_o=0. The request is still accepted and still responds.
- Response (pipeline stage, registered):
  - The response appears exactly 1 cycle after the grant. Back-to-back grants give back-to-back responses.
  - There is no response backpressure.
  - Fetch response: instr = mem_rdata_i, err=0. On fault: instr = NOP_INSTR, err=1.
  - Loader read: rdata = mem_rdata_i. Loader write: rdata = 0. Fault: rdata = 0, err=1, and no memory write occurs.
- Flush:
  - fetch_flush_i=1 in the cycle a fetch response is due suppresses fetch_rsp_valid_o that cycle.
  - A loader response is never affected by flush.
- Lock:
  - Asserting ld_lock_i does not cancel an already-granted fetch; its response still appears next cycle.
  - Deasserting ld_lock_i makes fetch eligible in the same cycle.
- Reset mid-operation: an in-flight response is discarded (no rsp_valid after reset), and the counter clears.

Optional Feature:
- IMEM_ARB_PERF_EN adds three outputs:
  - perf_fetch_grants_o [31:0]
  - perf_ld_grants_o [31:0]
  - perf_fetch_stall_o [31:0], counting cycles with fetch_req_valid_i=1 and no fetch grant.
- All three wrap on overflow and clear on reset.
- Without the macro the ports still exist and are tied to 0. No counter flops are built.

Test Plan:
- Fetch only: addr 0x0, 0x4, 0x8 on consecutive cycles, with mem returning 0x00100093, 0x00200113, 0x00400193 → three consecutive fetch_rsp_valid with those words, err=0.
- Contention: fetch and loader read both valid continuously, STARVE_LIMIT=8 → fetch granted 8 cycles, loader granted on the 9th, then fetch resumes. Repeat the pattern.
- Loader program: ld_lock_i=1, write 0x00100073 to addr 0xE4 → mem_we_o=1, mem_widx_o=57, ld_rsp_valid one cycle later with err=0. Concurrent fetch_req_valid_i stays unready.
- Faults:
  - fetch addr 0x6 → no mem_en, response NOP 0x00000013 with err=1;
  - fetch addr 0x1000 (MEM_WORDS=1024) → same;
  - loader write to 0x1000 → err=1, no write.
- Flush: fetch granted at cycle N, fetch_flush_i=1 at N+1 → no fetch_rsp_valid at N+1, and fetch_req_ready_o=0 at N+1.
- Reset mid-flight: grant at N, rst_n=0 at N+1 → all rsp_valid=0, starve counter=0. First grant after reset behaves normally.
